// File: rtl/pipo_pkg.sv
// Shared definitions for the PIPO bank, the issuer and its testbench:
// issuer state encoding and default data width / bank depth.
package pipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int N_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/pipo_wait_timer.sv
// WAIT-cycle counter for the issuer's done timeout; exists only when
// PIPO_ISSUER_TIMEOUT_EN is defined.
`ifdef PIPO_ISSUER_TIMEOUT_EN
module pipo_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] cnt;

  // expire flags the TIMEOUT-th consecutive enabled cycle
  assign expire = en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipo_issuer.sv
// Issues DEPTH buffered words to PIPO stages 0..DEPTH-1, one do_out strobe per
// stage, waiting for each stage's done. Optional abort: PIPO_ISSUER_TIMEOUT_EN.
module pipo_issuer
  import pipo_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          start,
  output logic          busy,
  output logic [N-1:0]  d_out,
  output logic          do_out,
  output logic [AW-1:0] sel,
  input  logic          done_in,
  output logic          finished,
  output logic          error
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_next;
  logic [N-1:0]  buf_q [DEPTH];
  logic          expire;

  assign idx_next = idx + 1'b1;

`ifdef PIPO_ISSUER_TIMEOUT_EN
  pipo_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state == ST_ISSUE),
    .en     (state == ST_WAIT),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      error <= 1'b0;
    end else if (state == ST_WAIT && !done_in && expire) begin
      error <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire = 1'b0;
  assign error  = 1'b0;
`endif

  // buffer is frozen while a sequence is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (wr_en && state == ST_IDLE) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      sel      <= '0;
      d_out    <= '0;
      do_out   <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      do_out   <= 1'b0;
      finished <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_ISSUE;
            idx    <= '0;
            sel    <= '0;
            busy   <= 1'b1;
            do_out <= 1'b1;
            // a write to entry 0 landing on this same edge must be issued
            d_out  <= (wr_en && wr_addr == '0) ? wr_data : buf_q[0];
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (done_in) begin
            if (idx == LAST) begin
              state    <= ST_FINISH;
              finished <= 1'b1;
            end else begin
              state  <= ST_ISSUE;
              idx    <= idx_next;
              sel    <= idx_next;
              d_out  <= buf_q[idx_next];
              do_out <= 1'b1;
            end
          end else if (expire) begin
            state    <= ST_FINISH;
            finished <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
